// File: rtl/tdm_pkg.sv
// Shared definitions for the 4:1 TDM channel mux/demux pair.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_t;

  localparam int unsigned TDM_NCH    = 4;
  localparam int unsigned TDM_W      = 1;
  localparam int unsigned SLOT_W     = $clog2(TDM_NCH);
  localparam int unsigned ERR_CNT_W  = 4;
  localparam int unsigned MISS_CNT_W = 4;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter, missing-sync counter and lock FSM for the TDM receiver.
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int unsigned NCH        = TDM_NCH,
  parameter int unsigned MISS_LIMIT = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     sync,
  output logic [$clog2(NCH)-1:0]   slot,
  output logic                     locked,
  output logic                     cap_en,
  output logic [$clog2(NCH)-1:0]   cap_idx,
  output logic                     frame_done,
  output logic                     resync
);

  localparam int unsigned SW = $clog2(NCH);

  tdm_state_t            state_q, state_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [MISS_CNT_W-1:0] miss_q, miss_d;

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    miss_d     = miss_q;
    cap_en     = 1'b0;
    cap_idx    = slot_q;
    frame_done = 1'b0;
    resync     = 1'b0;
    if (ena) begin
      unique case (state_q)
        HUNT: begin
          if (sync) begin
            cap_en  = 1'b1;
            cap_idx = '0;
            slot_d  = SW'(1);
            miss_d  = '0;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (slot_q == '0) begin
            if (sync) begin
              cap_en = 1'b1;
              slot_d = SW'(1);
              miss_d = '0;
            end else if (miss_q == MISS_CNT_W'(MISS_LIMIT - 1)) begin
              // Lock lost: the slot-0 sample is not captured.
              state_d = HUNT;
              slot_d  = '0;
              miss_d  = '0;
            end else begin
              cap_en = 1'b1;
              slot_d = SW'(1);
              miss_d = miss_q + 1'b1;
            end
          end else if (sync) begin
            resync  = 1'b1;
            cap_en  = 1'b1;
            cap_idx = '0;
            slot_d  = SW'(1);
            miss_d  = '0;
          end else begin
            cap_en     = 1'b1;
            frame_done = (slot_q == SW'(NCH - 1));
            slot_d     = slot_q + 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      slot_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      miss_q  <= miss_d;
    end
  end

  assign slot   = slot_q;
  assign locked = (state_q == LOCKED);

endmodule

// File: rtl/tdm_demux4_rx.sv
// TDM receiver: routes each slot of the multiplexed stream to its channel and
// publishes complete frames with a valid strobe, lock and sync-error status.
module tdm_demux4_rx
  import tdm_pkg::*;
#(
  parameter int unsigned NCH        = TDM_NCH,
  parameter int unsigned W          = TDM_W,
  parameter int unsigned MISS_LIMIT = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [W-1:0]           din,
  input  logic                   sync,
  output logic [NCH*W-1:0]       out_data,
  output logic                   frame_valid,
  output logic                   locked,
  output logic                   sync_err,
  output logic [ERR_CNT_W-1:0]   err_cnt,
  output logic [$clog2(NCH)-1:0] slot
);

  localparam int unsigned SW = $clog2(NCH);

  logic          cap_en;
  logic [SW-1:0] cap_idx;
  logic          frame_done;
  logic          resync;

  logic [NCH-1:0][W-1:0] stage;
  logic [NCH-1:0][W-1:0] frame_word;

  tdm_slot_ctr #(
    .NCH        (NCH),
    .MISS_LIMIT (MISS_LIMIT)
  ) u_slot_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .sync       (sync),
    .slot       (slot),
    .locked     (locked),
    .cap_en     (cap_en),
    .cap_idx    (cap_idx),
    .frame_done (frame_done),
    .resync     (resync)
  );

  // The last slot bypasses staging so the frame publishes on the same edge.
  always_comb begin
    frame_word          = stage;
    frame_word[NCH-1]   = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage       <= '0;
      out_data    <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      err_cnt     <= '0;
    end else begin
      frame_valid <= frame_done;
      sync_err    <= resync;
      if (cap_en) begin
        stage[cap_idx] <= din;
      end
      if (frame_done) begin
        out_data <= frame_word;
      end
      if (resync && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule
